shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 90 +++++++++
 tb/tb_shift_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: up to StepMax bit positions per SHIFT cycle, N = ceil(amount/StepMax) SHIFT cycles after accept.
// One request in flight; InReady only in IDLE, result held in DONE until OutReady is seen.
module shift_sequencer #(
  parameter int DataWidth = 32,
  parameter int StepMax   = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [DataWidth-1:0]         DataA,
  input  logic [$clog2(DataWidth)-1:0] ShiftAmount,
  input  logic [1:0]                   ShiftMode,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [DataWidth-1:0]         Result,
  output logic                         Busy
);

  localparam int AmtW = $clog2(DataWidth);
  localparam logic [AmtW:0] StepLim  = (AmtW+1)'(StepMax);
  localparam logic [AmtW:0] WidthLim = (AmtW+1)'(DataWidth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [DataWidth-1:0] data_q;
  logic [DataWidth-1:0] shifted;
  logic [AmtW-1:0]      remaining_q;
  logic [AmtW-1:0]      remaining_nxt;
  logic [1:0]           mode_q;
  logic [AmtW:0]        rem_ext;
  logic [AmtW:0]        step;
  logic [AmtW:0]        rot_back;

  always_comb begin
    rem_ext       = {1'b0, remaining_q};
    step          = (rem_ext > StepLim) ? StepLim : rem_ext;
    rot_back      = WidthLim - step;
    remaining_nxt = remaining_q - step[AmtW-1:0];
    shifted       = data_q;
    case (mode_q)
      2'd0:    shifted = data_q << step;
      2'd1:    shifted = data_q >> step;
      // Sign comes from the current MSB, which every earlier step has preserved.
      2'd2:    shifted = $signed(data_q) >>> step;
      default: shifted = (data_q << step) | (data_q >> rot_back);
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      mode_q      <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            data_q      <= DataA;
            remaining_q <= ShiftAmount;
            mode_q      <= ShiftMode;
            state_q     <= (ShiftAmount != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          data_q      <= shifted;
          remaining_q <= remaining_nxt;
          if (remaining_nxt == '0) state_q <= DONE;
        end
        DONE: begin
          if (OutReady) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset gates InReady so nothing is taken on the release edge's neighbourhood.
  assign InReady  = (state_q == IDLE) && !Reset;
  assign OutValid = (state_q == DONE);
  assign Busy     = (state_q != IDLE);
  assign Result   = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] DataA = '0;
  logic [4:0]  ShiftAmount = '0;
  logic [1:0]  ShiftMode = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] Result;
  logic        Busy;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .DataA       (DataA),
    .ShiftAmount (ShiftAmount),
    .ShiftMode   (ShiftMode),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Result      (Result),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({InReady, OutValid, Busy} !== 3'b000 || Result !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b res=%h, want 0 0 0 00000000",
               InReady, OutValid, Busy, Result);
    end
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (InReady !== 1'b1 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got rdy=%b busy=%b, want 1 0", InReady, Busy);
    end
  endtask

  // Issues one request with OutReady high; exp_n is edges after accept until OutValid.
  task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] amt,
                        input logic [1:0] mode, input logic [31:0] exp, input int exp_n);
    int n;
    @(negedge Clock);
    InValid = 1'b1; DataA = a; ShiftAmount = amt; ShiftMode = mode; OutReady = 1'b1;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    n_cmp++;
    if (Busy !== 1'b1 || InReady !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_accept: got busy=%b rdy=%b, want 1 0", name, Busy, InReady);
    end
    n = 0;
    while (OutValid !== 1'b1 && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
    end
    n_cmp++;
    if (OutValid !== 1'b1 || n != exp_n) begin
      n_bad++;
      $display("FAIL %s_latency: got vld=%b after %0d edges, want vld=1 after %0d", name, OutValid, n, exp_n);
    end
    n_cmp++;
    if (Result !== exp) begin
      n_bad++;
      $display("FAIL %s_result: got %h, want %h", name, Result, exp);
    end
    @(posedge Clock);
    #1;
    n_cmp++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: got vld=%b rdy=%b busy=%b, want 0 1 0", name, OutValid, InReady, Busy);
    end
  endtask

  task automatic test_shift_modes();
    run_op("lsl5",    32'h00000001, 5'd5,  2'd0, 32'h00000020, 2);
    run_op("asr31",   32'h80000000, 5'd31, 2'd2, 32'hFFFFFFFF, 8);
    run_op("lsr31",   32'h80000000, 5'd31, 2'd1, 32'h00000001, 8);
    run_op("rol4",    32'h80000001, 5'd4,  2'd3, 32'h00000018, 1);
    run_op("pass0",   32'h12345678, 5'd0,  2'd0, 32'h12345678, 0);
    run_op("lsr7",    32'hF0000000, 5'd7,  2'd1, 32'h01E00000, 2);
    run_op("asr3",    32'h80000000, 5'd3,  2'd2, 32'hF0000000, 1);
    run_op("rol31",   32'h00000001, 5'd31, 2'd3, 32'h80000000, 8);
    run_op("asr9pos", 32'h7FFF0000, 5'd9,  2'd2, 32'h003FFF80, 3);
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge Clock);
    InValid = 1'b1; DataA = 32'h0000000F; ShiftAmount = 5'd8; ShiftMode = 2'd0; OutReady = 1'b0;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    n = 0;
    while (OutValid !== 1'b1 && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
    end
    n_cmp++;
    if (OutValid !== 1'b1 || n != 2) begin
      n_bad++;
      $display("FAIL bp_latency: got vld=%b after %0d edges, want vld=1 after 2", OutValid, n);
    end
    @(negedge Clock);
    InValid = 1'b1; DataA = 32'hA5A5A5A5; ShiftAmount = 5'd0; ShiftMode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #1;
      n_cmp++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || Busy !== 1'b1 || Result !== 32'h00000F00) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b busy=%b res=%h, want 1 0 1 00000f00",
                 i, OutValid, InReady, Busy, Result);
      end
    end
    @(negedge Clock);
    OutReady = 1'b1;
    @(posedge Clock);
    #1;
    n_cmp++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Result !== 32'h00000F00) begin
      n_bad++;
      $display("FAIL bp_release: got vld=%b rdy=%b res=%h, want 0 1 00000f00", OutValid, InReady, Result);
    end
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    n_cmp++;
    if (OutValid !== 1'b1 || Result !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL bp_next_accept: got vld=%b res=%h, want 1 a5a5a5a5", OutValid, Result);
    end
    @(posedge Clock);
    #1;
    n_cmp++;
    if (OutValid !== 1'b0 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_next_drain: got vld=%b busy=%b, want 0 0", OutValid, Busy);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge Clock);
    InValid = 1'b1; DataA = 32'hFFFF0000; ShiftAmount = 5'd20; ShiftMode = 2'd1; OutReady = 1'b1;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_cmp++;
    if (Busy !== 1'b1 || OutValid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pre: got busy=%b vld=%b, want 1 0", Busy, OutValid);
    end
    #1;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || OutValid !== 1'b0 || Result !== 32'h0 || InReady !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: got busy=%b vld=%b res=%h rdy=%b, want 0 0 00000000 0",
               Busy, OutValid, Result, InReady);
    end
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (InReady !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release_rdy: got %b, want 1", InReady);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock);
      #1;
      n_cmp++;
      if (OutValid !== 1'b0 || Busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_no_stale%0d: got vld=%b busy=%b, want 0 0", i, OutValid, Busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_modes();
    test_backpressure();
    test_reset_mid_op();
    run_op("post_rst", 32'h00000003, 5'd2, 2'd0, 32'h0000000C, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
